// File: rtl/nios_dct_pkg.sv
// Shared constants and types for the Nios II OCI data-capture-trace frame sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nios_dct_pkg;

    localparam int SYM_W  = 2;              // bits per trace symbol
    localparam int DEPTH  = 15;             // symbols per full frame
    localparam int BUF_W  = SYM_W * DEPTH;  // packed frame width (30)
    localparam int CNT_W  = 4;              // symbol count width, holds 0..15
    localparam int DROP_W = 16;             // drop counter width (DCT_DROP_CNT_EN builds)

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ENDED = 2'd2
    } dct_state_t;

    typedef struct packed {
        logic [BUF_W-1:0] data;   // newest symbol in the low bits
        logic [CNT_W-1:0] count;  // valid symbols, 1..DEPTH
    } frame_t;

endpackage

// File: rtl/nios_dct_hold_reg.sv
// One-deep valid/ready holding register for a W-bit payload.
// Latency: 1 cycle from load to out_vld.
// Backpressure: payload held stable while out_vld & !out_rdy; free tells the writer when a load is allowed.
// Ports: clk, reset_n (async active-low), load/load_dat (write side), out_vld/out_rdy/out_dat (read side), free.
module nios_dct_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat,
    output logic         free
);

    // Empty, or the current word leaves this cycle.
    assign free = !out_vld | out_rdy;

    // The writer only raises load while free is high, so a load never
    // overwrites a word the sink has not taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (load) begin
            out_vld <= 1'b1;
            out_dat <= load_dat;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/nios_dct_frame_ctrl.sv
// Packs 2-bit trace symbols into 15-symbol frames, hands them to the sink and drains on end of test.
// Latency: frame_valid is registered, one cycle after the frame is complete or flushed and the holding register is free.
// Backpressure: sink stalls with frame_ready; the source cannot stall, so a symbol meeting a full accumulator and a blocked holding register is dropped.
// Optional: define DCT_DROP_CNT_EN to add the saturating drop_count output.
// Ports: clk, reset_n; sym_valid/sym_data (symbol in); flush_req, test_ending (control);
//        frame_valid/frame_ready/frame_data/frame_count (frame out); busy, test_has_ended (status).
module nios_dct_frame_ctrl
    import nios_dct_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sym_valid,
    input  logic [SYM_W-1:0]  sym_data,
    input  logic              flush_req,
    input  logic              test_ending,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [BUF_W-1:0]  frame_data,
    output logic [CNT_W-1:0]  frame_count,
    output logic              busy,
`ifdef DCT_DROP_CNT_EN
    output logic [DROP_W-1:0] drop_count,
`endif
    output logic              test_has_ended
);

    logic [BUF_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             flush_pend;
    dct_state_t       state, state_nxt;

    logic   hold_free;
    logic   full, nonempty;
    logic   xfer, accept, absorb;
    frame_t load_frame, hold_q;

    assign full     = (cnt == CNT_W'(DEPTH));
    assign nonempty = (cnt != '0);

    assign xfer   = hold_free &
                    (full | ((flush_req | flush_pend | (state == DRAIN)) & nonempty));
    assign accept = sym_valid & (state == RUN) & (!full | xfer);

    // A transfer that is not caused by a full accumulator is a flush; a
    // symbol arriving in that cycle still fits and belongs to the flushed
    // frame. On a full transfer the symbol starts the next frame instead.
    assign absorb = accept & !full;

    always_comb begin
        load_frame.data  = acc;
        load_frame.count = cnt;
        if (absorb) begin
            load_frame.data  = {acc[BUF_W-SYM_W-1:0], sym_data};
            load_frame.count = cnt + CNT_W'(1);
        end
    end

    // Accumulator. Cleared on transfer so a short frame has zero upper bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (xfer) begin
            if (accept && full) begin
                acc <= {{(BUF_W-SYM_W){1'b0}}, sym_data};
                cnt <= CNT_W'(1);
            end else begin
                acc <= '0;
                cnt <= '0;
            end
        end else if (accept) begin
            acc <= {acc[BUF_W-SYM_W-1:0], sym_data};
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Remembers a flush that arrived while the holding register was blocked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_pend <= 1'b0;
        end else if (xfer) begin
            flush_pend <= 1'b0;
        end else if (flush_req && nonempty && !hold_free) begin
            flush_pend <= 1'b1;
        end
    end

    nios_dct_hold_reg #(
        .W ($bits(frame_t))
    ) u_hold (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (xfer),
        .load_dat (load_frame),
        .out_vld  (frame_valid),
        .out_rdy  (frame_ready),
        .out_dat  (hold_q),
        .free     (hold_free)
    );

    assign frame_data  = hold_q.data;
    assign frame_count = hold_q.count;
    assign busy        = nonempty | frame_valid;

    // End-of-test sequencing. DRAIN completes once nothing is left in the
    // accumulator and the held frame is gone or leaving this cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (test_ending) state_nxt = DRAIN;
            DRAIN:   if (!nonempty && hold_free) state_nxt = ENDED;
            ENDED:   state_nxt = ENDED;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RUN;
            test_has_ended <= 1'b0;
        end else begin
            state          <= state_nxt;
            test_has_ended <= (state_nxt == ENDED);
        end
    end

`ifdef DCT_DROP_CNT_EN
    logic drop;
    assign drop = sym_valid & (state == RUN) & full & !xfer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != {DROP_W{1'b1}})) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_nios_dct_frame_ctrl.sv
// Self-checking bench for nios_dct_frame_ctrl: frame packing table plus stall, flush, drain and reset sequences.
// Latency: n/a.
// Backpressure: frame_ready driven by the bench.
module tb_nios_dct_frame_ctrl;
    import nios_dct_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             sym_valid;
    logic [SYM_W-1:0] sym_data;
    logic             flush_req;
    logic             test_ending;
    logic             frame_valid;
    logic             frame_ready;
    logic [BUF_W-1:0] frame_data;
    logic [CNT_W-1:0] frame_count;
    logic             busy;
    logic             test_has_ended;
`ifdef DCT_DROP_CNT_EN
    logic [DROP_W-1:0] drop_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nios_dct_frame_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sym_valid      (sym_valid),
        .sym_data       (sym_data),
        .flush_req      (flush_req),
        .test_ending    (test_ending),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .frame_data     (frame_data),
        .frame_count    (frame_count),
        .busy           (busy),
`ifdef DCT_DROP_CNT_EN
        .drop_count     (drop_count),
`endif
        .test_has_ended (test_has_ended)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input int n, input logic [SYM_W-1:0] val);
        for (int i = 0; i < n; i++) begin
            sym_valid = 1'b1;
            sym_data  = val;
            tick();
        end
        sym_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    typedef struct {
        int               n;        // symbols fed
        int               start;    // first symbol value
        int               step;     // increment between symbols (mod 4)
        logic [CNT_W-1:0] exp_cnt;
        logic [BUF_W-1:0] exp_dat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{15, 0, 1, 4'd15, 30'h06C6C6C6};
        vecs[1] = '{ 4, 3, 3, 4'd4,  30'h000000E4};
        vecs[2] = '{ 1, 3, 0, 4'd1,  30'h00000003};
        vecs[3] = '{ 7, 1, 0, 4'd7,  30'h00001555};
        vecs[4] = '{14, 2, 0, 4'd14, 30'h0AAAAAAA};
        vecs[5] = '{ 4, 0, 1, 4'd4,  30'h0000001B};

        reset_n     = 1'b0;
        sym_valid   = 1'b0;
        sym_data    = '0;
        flush_req   = 1'b0;
        test_ending = 1'b0;
        frame_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_frame_data",  32'(frame_data),  32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_ended",       32'(test_has_ended), 32'd0);
        reset_n = 1'b1;
        tick();

        // Packing table: full frames and flushed partial frames, ready held high
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                sym_valid = 1'b1;
                sym_data  = SYM_W'((vecs[v].start + vecs[v].step * i) % 4);
                tick();
            end
            sym_valid = 1'b0;
            check($sformatf("v%0d_busy_fill", v), 32'(busy), 32'd1);
            if (vecs[v].n == DEPTH) begin
                check($sformatf("v%0d_valid_early", v), 32'(frame_valid), 32'd0);
                tick();
            end else begin
                pulse_flush();
            end
            check($sformatf("v%0d_valid", v), 32'(frame_valid), 32'd1);
            check($sformatf("v%0d_count", v), 32'(frame_count), 32'(vecs[v].exp_cnt));
            check($sformatf("v%0d_data", v),  32'(frame_data),  32'(vecs[v].exp_dat));
            tick();
            check($sformatf("v%0d_valid_drop", v), 32'(frame_valid), 32'd0);
            check($sformatf("v%0d_busy_idle", v),  32'(busy), 32'd0);
        end

        // Flush with an empty accumulator yields no frame
        pulse_flush();
        check("empty_flush_valid", 32'(frame_valid), 32'd0);
        tick();
        check("empty_flush_valid2", 32'(frame_valid), 32'd0);

        // Symbol coincident with flush_req is part of the flushed frame
        send(1, 2'd1);
        send(1, 2'd2);
        send(1, 2'd3);
        sym_valid = 1'b1;
        sym_data  = 2'd0;
        flush_req = 1'b1;
        tick();
        sym_valid = 1'b0;
        flush_req = 1'b0;
        check("coinc_valid", 32'(frame_valid), 32'd1);
        check("coinc_count", 32'(frame_count), 32'd4);
        check("coinc_data",  32'(frame_data),  32'h6C);
        tick();
        check("coinc_busy", 32'(busy), 32'd0);

        // Stalled sink: 31 symbols, the last one is dropped
        frame_ready = 1'b0;
        for (int i = 0; i < 31; i++) begin
            sym_valid = 1'b1;
            sym_data  = SYM_W'(i % 4);
            tick();
        end
        sym_valid = 1'b0;
        check("stall_valid", 32'(frame_valid), 32'd1);
        check("stall_count", 32'(frame_count), 32'd15);
        check("stall_data",  32'(frame_data),  32'h06C6C6C6);
`ifdef DCT_DROP_CNT_EN
        check("stall_drop_count", 32'(drop_count), 32'd1);
`endif
        tick();
        tick();
        check("stall_data_stable", 32'(frame_data), 32'h06C6C6C6);
        check("stall_busy", 32'(busy), 32'd1);
        frame_ready = 1'b1;
        tick();
        check("stall_f2_valid", 32'(frame_valid), 32'd1);
        check("stall_f2_count", 32'(frame_count), 32'd15);
        check("stall_f2_data",  32'(frame_data),  32'h31B1B1B1);
        tick();
        check("stall_f2_done", 32'(frame_valid), 32'd0);
        check("stall_busy_idle", 32'(busy), 32'd0);

        // Flush while stalled is remembered and executed when the sink frees up
        frame_ready = 1'b0;
        send(15, 2'd0);
        send(7, 2'd2);
        pulse_flush();
        check("pend_set",        32'(dut.flush_pend), 32'd1);
        check("pend_held_count", 32'(frame_count), 32'd15);
        tick();
        tick();
        check("pend_held_valid", 32'(frame_valid), 32'd1);
        check("pend_held_count2", 32'(frame_count), 32'd15);
        frame_ready = 1'b1;
        tick();
        check("pend_part_valid", 32'(frame_valid), 32'd1);
        check("pend_part_count", 32'(frame_count), 32'd7);
        check("pend_part_data",  32'(frame_data),  32'h2AAA);
        check("pend_clear",      32'(dut.flush_pend), 32'd0);
        tick();
        check("pend_done", 32'(frame_valid), 32'd0);
        tick();
        check("pend_no_extra", 32'(frame_valid), 32'd0);

        // End of test drain, 5th symbol coincident with test_ending
        send(4, 2'd3);
        sym_valid   = 1'b1;
        sym_data    = 2'd1;
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        sym_data    = 2'd3;
        check("drain_ended_early", 32'(test_has_ended), 32'd0);
        tick();
        check("drain_valid", 32'(frame_valid), 32'd1);
        check("drain_count", 32'(frame_count), 32'd5);
        check("drain_data",  32'(frame_data),  32'h3FD);
        check("drain_ended_wait", 32'(test_has_ended), 32'd0);
        tick();
        check("drain_ended", 32'(test_has_ended), 32'd1);
        check("drain_valid_off", 32'(frame_valid), 32'd0);
        test_ending = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        test_ending = 1'b0;
        sym_valid   = 1'b0;
        check("ended_sticky", 32'(test_has_ended), 32'd1);
        check("ended_no_frame", 32'(frame_valid), 32'd0);
        check("ended_busy", 32'(busy), 32'd0);
`ifdef DCT_DROP_CNT_EN
        check("ended_drop_count", 32'(drop_count), 32'd1);
`endif

        // Asynchronous reset mid-frame
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        frame_ready = 1'b0;
        send(24, 2'd3);
        check("pre_rst_valid", 32'(frame_valid), 32'd1);
        check("pre_rst_busy",  32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(frame_valid), 32'd0);
        check("arst_count", 32'(frame_count), 32'd0);
        check("arst_data",  32'(frame_data),  32'd0);
        check("arst_busy",  32'(busy),        32'd0);
        check("arst_ended", 32'(test_has_ended), 32'd0);
        tick();
        reset_n     = 1'b1;
        frame_ready = 1'b1;
        tick();
        send(3, 2'd1);
        pulse_flush();
        check("post_rst_valid", 32'(frame_valid), 32'd1);
        check("post_rst_count", 32'(frame_count), 32'd3);
        check("post_rst_data",  32'(frame_data),  32'h15);
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
